// File: rtl/sync_ram_clr.sv
// Single-port synchronous RAM with per-lane write enables, a configurable read
// pipeline and a clear sequencer that fills the array with CLR_VAL.
//
// Handshake: there is no back-pressure. In IDLE, an access with nCE=0 is
// accepted on every rising edge. While BUSY=1, every access is dropped. A read
// accepted at an edge appears on DO with DO_VALID=1 for exactly one cycle,
// RD_LAT cycles after the cycle in which it was presented.
module sync_ram_clr #(
  parameter int              AW           = 7,
  parameter int              DW           = 8,
  parameter int              LANES        = 1,
  parameter int              RD_LAT       = 1,
  parameter logic [DW-1:0]   CLR_VAL      = '0,
  parameter bit              CLR_ON_RESET = 1'b1
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic              nCE,
  input  logic              nWE,
  input  logic              nOE,
  input  logic [AW-1:0]     A,
  input  logic [DW-1:0]     DI,
  input  logic [LANES-1:0]  BE,
  input  logic              CLR,
  output logic [DW-1:0]     DO,
  output logic              DO_VALID,
  output logic              DOE,
  output logic              BUSY,
  output logic              dbg_state
);

  localparam int LW    = DW / LANES;
  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] clr_cnt;
  logic [AW-1:0] clr_cnt_nxt;

  logic          busy;
  logic          clr_we;
  logic          wr_acc;
  logic          rd_acc;

  logic [DW-1:0] mem [DEPTH];

  logic [DW-1:0] pipe_d [RD_LAT];
  logic [RD_LAT-1:0] pipe_v;

  // State register: reset lands directly in CLEAR when auto-clear is enabled.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state   <= CLR_ON_RESET ? S_CLEAR : S_IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Next-state logic. The counter wraps to zero naturally after the last word.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      S_IDLE: begin
        if (CLR) begin
          state_nxt   = S_CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      S_CLEAR: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == {AW{1'b1}}) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt   = S_IDLE;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  // Output logic: the clear owns the array, so host accesses are masked.
  always_comb begin
    busy   = (state == S_CLEAR);
    clr_we = busy;
    wr_acc = !busy && !nCE && !nWE;
    rd_acc = !busy && !nCE &&  nWE;
  end

  // Array storage is intentionally not reset.
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem[clr_cnt] <= CLR_VAL;
    end else if (wr_acc) begin
      for (int i = 0; i < LANES; i++) begin
        if (BE[i]) begin
          mem[A][i*LW +: LW] <= DI[i*LW +: LW];
        end
      end
    end
  end

  // Read pipeline. Each stage only loads when its input is valid, so the last
  // stage (DO) holds the most recent read data between reads.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      pipe_v <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_d[i] <= '0;
      end
    end else begin
      pipe_v[0] <= rd_acc;
      if (rd_acc) begin
        pipe_d[0] <= mem[A];
      end
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) begin
          pipe_d[i] <= pipe_d[i-1];
        end
      end
    end
  end

  assign DO        = pipe_d[RD_LAT-1];
  assign DO_VALID  = pipe_v[RD_LAT-1];
  assign DOE       = DO_VALID & ~nOE;
  assign BUSY      = busy;
  assign dbg_state = state;

endmodule

// File: doc/sync_ram_clr.md
Name: sync_ram_clr

Overview:
Parametrised single-port synchronous RAM for the uPD7800 system model. It succeeds the fixed 128x8 work-RAM model and adds:
- configurable width, depth and read latency;
- per-lane write enables;
- a hardware clear sequencer that fills the array after reset or on request.

It sits behind the CPU address decoder (e.g. 'hFF80-'hFFFF work RAM) and is also used for wider video/sprite RAM.

Parameters:
AW, 7, address width; depth = 2**AW words.
DW, 8, data width; must be a multiple of LANES.
LANES, 1, number of independently writable lanes, each DW/LANES bits.
RD_LAT, 1, read latency in CLK cycles, legal 1..3.
CLR_VAL, 0, DW-bit value written to every word by the clear sequencer.
CLR_ON_RESET, 1, 1 = clear sequence starts automatically when RES deasserts.

Ports:
CLK  in  1  clock; all state changes on rising edge.
RES  in  1  reset, asynchronous, active-high.
nCE  in  1  chip enable, active low.
nWE  in  1  write enable, active low; high with nCE low = read.
nOE  in  1  output enable, active low; gates DOE only.
A  in  AW  word address.
DI  in  DW  write data.
BE  in  LANES  lane write enables, active high.
CLR  in  1  clear request; single-cycle pulse or level.
DO  out  DW  read data.
DO_VALID  out  1  DO carries data for a read issued RD_LAT cycles earlier.
DOE  out  1  DO_VALID & ~nOE (combinational).
BUSY  out  1  clear sequence in progress; all accesses are ignored.

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to CLEAR with clear counter 0 if CLR_ON_RESET=1, else to IDLE.
  - BUSY = CLR_ON_RESET, DO = 0, DO_VALID = 0, read pipeline valid bits cleared.
  - Array contents are not reset.
- FSM states:
  - IDLE: accesses accepted. CLR=1 at an edge -> CLEAR, counter 0, BUSY=1 from the next cycle.
  - CLEAR: each cycle writes CLR_VAL to word[counter] (all lanes), then counter+1. After writing word 2**AW-1 -> IDLE. The clear takes exactly 2**AW cycles with BUSY=1. CLR is ignored while in CLEAR.
- Write (IDLE, nCE=0, nWE=0): at the edge, each lane i with BE[i]=1 takes DI lane i. Lanes with BE[i]=0 keep their value. BE all-zero = no-op.
- Read (IDLE, nCE=0, nWE=1): word[A] is sampled at the issuing edge. DO/DO_VALID present it RD_LAT edges later, for exactly one cycle.
  - One read per cycle is accepted, fully pipelined.
  - Between reads, DO holds its last value and DO_VALID=0.
- Read after write to the same address on the next cycle returns the new data.
- Any access during BUSY is dropped: no write, and no pipeline entry.
- Reads already in flight when CLEAR starts still complete with their originally sampled data.
- RES asserted mid-clear restarts the clear at word 0 (when CLR_ON_RESET=1) and flushes the read pipeline.
- Address wraps are not possible; A is exactly AW bits.

Test Plan:
- AW=4, DW=8, CLR_VAL='hA5, CLR_ON_RESET=1: release RES -> BUSY high exactly 16 cycles; then reads of all 16 addresses return 'hA5.
- DW=16, LANES=2: write 'h1234 BE=11 to addr 3, then 'hABCD BE=01 -> read addr 3 returns 'h12CD.
- RD_LAT=3: back-to-back reads of addr 0,1,2 holding 'h10,'h11,'h12 -> DO_VALID high on cycles 3,4,5 after the first read, with those values. nOE=1 keeps DOE=0 while DO_VALID=1.
- Write 'h5A to addr 7 in IDLE, pulse CLR, then attempt a write of 'hFF to addr 7 during BUSY -> after the clear, addr 7 reads CLR_VAL (not 'hFF, not 'h5A).
- Assert RES at clear count 9, release -> BUSY lasts a full 2**AW cycles again; DO_VALID stays 0 throughout.
- Read addr 2 issued the cycle before the CLR edge, RD_LAT=2 -> DO_VALID asserts with the pre-clear data while BUSY=1.
